bit_deser: RTL
==============

# bit_deser

Serial-to-parallel deserializer for the 1-bit gated data stream produced by the reset-gated pass-through stage (`q`, forced to 0 while that stage is held in reset). Samples the stream on a qualifying strobe, packs bits into WIDTH-bit words, and hands them downstream over a valid/ready handshake through a one-word holding register. Sits directly downstream of the gating stage and feeds the word-level datapath.

## Interface

Parameters:
- `WIDTH`, 8, data bits per word (2..32).
- `MSB_FIRST`, 1, 1 = first received bit lands in `out_data[WIDTH-1]`; 0 = first bit lands in `out_data[0]`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_bit`  in  1  serial data from the gating stage.
- `in_en`  in  1  sample strobe; `in_bit` is captured on a rising edge where `in_en`=1.
- `out_data`  out  WIDTH  completed word.
- `out_valid`  out  1  `out_data` holds an unconsumed word.
- `out_ready`  in  1  downstream accepts the word when `out_valid`&&`out_ready`.
- `ovf`  out  1  sticky overflow: a completed word was dropped.
- `ovf_clr`  in  1  synchronous clear of `ovf`.
- `parity_err`  out  1  parity flag for the word in `out_data` (see Configuration).

## Operation

- State: shift register `sr[WIDTH-1:0]`, bit counter `cnt` (0..FRAME-1, FRAME = WIDTH, or WIDTH+1 with parity), holding register + `out_valid`, `ovf`.
- Counter FSM: COLLECT only; `cnt` increments on each `in_en`; at `cnt`=FRAME-1 with `in_en`, word completes and `cnt` wraps to 0 in the same edge.
- Shift: MSB_FIRST=1: `sr <= {sr[WIDTH-2:0], in_bit}`; MSB_FIRST=0: `sr <= {in_bit, sr[WIDTH-1:1]}`.
- Completion load: the final data bit is merged combinationally so the completed word includes the bit sampled on the completing edge.
- Holding register outcomes at completion edge:
  - `out_valid`=0: load word, `out_valid`<=1.
  - `out_valid`=1 and `out_ready`=1 (simultaneous consume): load new word, `out_valid` stays 1.
  - `out_valid`=1 and `out_ready`=0: new word dropped, held word unchanged, `ovf`<=1.
- Without completion: `out_valid`&&`out_ready` clears `out_valid`; `out_data` retains its last value.
- `ovf`: set as above; cleared by `ovf_clr`; a set event on the same edge as `ovf_clr` wins (stays 1).
- Deserializer never back-pressures the input; the stream always keeps shifting.

## Timing

- Reset (async assert, sync-safe release): `sr`=0, `cnt`=0, `out_data`=0, `out_valid`=0, `ovf`=0, `parity_err`=0.
- Reset mid-word discards the partial word; the first `in_en` after release is bit 0 of a new frame.
- Latency: `out_valid` rises on the same edge that samples the last frame bit (visible the cycle after that bit is presented).
- Back-to-back: with `in_en`=1 every cycle and `out_ready`=1, one word per FRAME cycles, no bubbles, no overflow.
- `out_data`/`parity_err` stable while `out_valid`=1 and `out_ready`=0.
- `in_en`=0 cycles freeze `sr` and `cnt`; no timeout.

## Configuration

- `BIT_DESER_PARITY_EN` defined: FRAME = WIDTH+1; the extra final bit is an even-parity bit over the data bits (not stored in `out_data`); `parity_err` = 1 when XOR of data bits and parity bit is 1, loaded and held alongside `out_data`; overflow drop discards its parity too.
- Not defined: FRAME = WIDTH; `parity_err` tied to 0.

## Test plan

- Reset then WIDTH=8, MSB_FIRST=1, `in_en`=1, bits 1,0,1,0,0,1,0,1 -> `out_valid`=1 after 8th edge, `out_data`=0xA5, `ovf`=0.
- MSB_FIRST=0, same bits -> `out_data`=0xA5 reversed = 0xA5 check replaced by bits 1,1,0,0,0,0,0,0 -> `out_data`=0x03.
- Two words 0x3C then 0xC3, `out_ready` held 0 -> `out_data`=0x3C, `ovf`=1; `ovf_clr` pulse -> `ovf`=0, `out_data` still 0x3C.
- Continuous stream 0x11,0x22,0x33 with `out_ready`=1 every cycle, word-completion edge coinciding with consume -> three handshakes in 24 cycles, `out_valid` never drops between words, `ovf`=0.
- Assert `rst` after 5 bits, release, send 0x5A -> `out_data`=0x5A, no stale bits; all outputs 0 during reset.
- With `BIT_DESER_PARITY_EN`: 0xA5 + parity 0 -> `parity_err`=0; 0xA5 + parity 1 -> `parity_err`=1; `in_en` gaps of 3 cycles between bits give identical results.

Source files
------------

// File: rtl/bit_deser_if.sv
// Word-side and serial-side signal bundle for bit_deser.
// master = deserializer view, slave = upstream/downstream environment view.
interface bit_deser_if #(
  parameter int WIDTH = 8
);
  logic             in_bit;
  logic             in_en;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             ovf;
  logic             ovf_clr;
  logic             parity_err;

  modport master (
    input  in_bit,
    input  in_en,
    input  out_ready,
    input  ovf_clr,
    output out_data,
    output out_valid,
    output ovf,
    output parity_err
  );

  modport slave (
    output in_bit,
    output in_en,
    output out_ready,
    output ovf_clr,
    input  out_data,
    input  out_valid,
    input  ovf,
    input  parity_err
  );
endinterface

// File: rtl/bit_deser.sv
// Serial-to-parallel deserializer with a one-word valid/ready holding register.
// Optional trailing even-parity bit per frame: define BIT_DESER_PARITY_EN.
module bit_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  bit_deser_if.master bus
);

`ifdef BIT_DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
      $error("bit_deser: WIDTH must be in 2..32");
    end
  endgenerate

  typedef enum logic {COLLECT = 1'b0} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
  logic             complete;

  logic [WIDTH-1:0] word_c;
  logic             perr_c;
  logic             load, drop;

  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             ovf_q;
  logic             perr_q;

  // State register: framing counter and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  always_comb begin
    if (MSB_FIRST) sr_shift = {sr_q[WIDTH-2:0], bus.in_bit};
    else           sr_shift = {bus.in_bit, sr_q[WIDTH-1:1]};
  end

  // Next-state: count strobes, wrap at the last frame bit on the same edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    complete = 1'b0;
    case (state_q)
      COLLECT: begin
        if (bus.in_en) begin
          sr_d = sr_shift;
          if (cnt_q == CW'(FRAME - 1)) begin
            complete = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Output decode. Without parity the completing bit is merged in from
  // sr_shift; with parity the data is already whole in sr_q and the
  // completing bit is the parity bit itself.
  always_comb begin
`ifdef BIT_DESER_PARITY_EN
    word_c = sr_q;
    perr_c = (^sr_q) ^ bus.in_bit;
`else
    word_c = sr_shift;
    perr_c = 1'b0;
`endif
    load = complete && (!valid_q || bus.out_ready);
    drop = complete && valid_q && !bus.out_ready;
  end

  // Holding register: parity flag travels with the word it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (load) begin
        data_q  <= word_c;
        perr_q  <= perr_c;
        valid_q <= 1'b1;
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end
      if (drop)             ovf_q <= 1'b1;
      else if (bus.ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.ovf       = ovf_q;
`ifdef BIT_DESER_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
